// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS CPU: fetch FSM states, IF/ID
// bundle layout, reset/NOP constants and small PC helpers.
package cpu_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } if_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } ifid_t;

  // Sequential successor; wraps naturally at 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// Single-entry buffer that parks an instruction-memory response while the
// decode stage is stalled. Clear wins over load, load wins over take.
module if_hold_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_take,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic        o_valid,
  output logic [31:0] o_data
);

  logic        r_valid;
  logic [31:0] r_data;

  // Capture a response on load, empty the entry on take or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= NOP_INST;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= NOP_INST;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_take) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory read at
// a time and loads the IF/ID register, honouring decode stalls and redirects.
// Optional macro IF_STAGE_DELAY_SLOT_EN enables MIPS branch-delay-slot
// behaviour; without it a redirect flushes (bubble in IF/ID, stale response
// dropped).
module if_stage #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        id_stall,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst
);

  import cpu_pkg::*;

  localparam logic [31:0] START_PC = word_align(RESET_PC);

  if_state_t   r_state;
  if_state_t   w_nextState;
  logic [31:0] r_fetchPc;
  logic [31:0] w_fetchNext;
  logic [31:0] r_reqAddr;
  logic [31:0] w_reqAddrNext;
  ifid_t       r_ifid;
  ifid_t       w_ifidNext;
  logic [31:0] w_target;
  logic [31:0] w_advPc;
  logic        w_deliver;
  logic [31:0] w_deliverData;
  logic        w_holdLoad;
  logic        w_holdTake;
  logic        w_holdClear;
  logic        w_holdValid;
  logic [31:0] w_holdData;

  assign w_target = word_align(id_target);

`ifdef IF_STAGE_DELAY_SLOT_EN
  logic        r_pendValid;
  logic [31:0] r_pendTarget;
  logic        w_pendValidNext;
  logic [31:0] w_pendTargetNext;
  logic        w_redirAcc;
  logic        w_havePend;
  logic [31:0] w_pendTgt;

  // A redirect seen this cycle counts as pending immediately, so a delay-slot
  // instruction delivered in the same cycle already steers fetch to the target.
  assign w_redirAcc = id_redirect & ~id_stall;
  assign w_havePend = r_pendValid | w_redirAcc;
  assign w_pendTgt  = w_redirAcc ? w_target : r_pendTarget;
  assign w_advPc    = w_havePend ? w_pendTgt : pc_plus4(r_fetchPc);
`else
  assign w_advPc    = pc_plus4(r_fetchPc);
`endif

  if_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_holdLoad),
    .i_take  (w_holdTake),
    .i_clear (w_holdClear),
    .i_data  (imem_rdata),
    .o_valid (w_holdValid),
    .o_data  (w_holdData)
  );

  // Next-state, next-PC and IF/ID update decisions for the fetch FSM.
  always_comb begin
    w_nextState   = r_state;
    w_fetchNext   = r_fetchPc;
    w_ifidNext    = r_ifid;
    w_deliver     = 1'b0;
    w_deliverData = NOP_INST;
    w_holdLoad    = 1'b0;
    w_holdTake    = 1'b0;
    w_holdClear   = 1'b0;

    case (r_state)
      FETCH: begin
        if (id_stall) begin
          if (imem_rvalid) begin
            w_holdLoad  = 1'b1;
            w_nextState = HOLD;
          end
        end else begin
`ifdef IF_STAGE_DELAY_SLOT_EN
          if (imem_rvalid) begin
            w_deliver     = 1'b1;
            w_deliverData = imem_rdata;
          end
`else
          if (id_redirect) begin
            w_fetchNext      = w_target;
            w_ifidNext.valid = 1'b0;
            w_ifidNext.inst  = NOP_INST;
            w_holdClear      = 1'b1;
            if (!imem_rvalid) begin
              w_nextState = DROP;
            end
          end else if (imem_rvalid) begin
            w_deliver     = 1'b1;
            w_deliverData = imem_rdata;
          end
`endif
        end
      end

      HOLD: begin
        if (!id_stall) begin
          w_nextState = FETCH;
`ifdef IF_STAGE_DELAY_SLOT_EN
          w_holdTake    = 1'b1;
          w_deliver     = w_holdValid;
          w_deliverData = w_holdData;
`else
          if (id_redirect) begin
            w_fetchNext      = w_target;
            w_ifidNext.valid = 1'b0;
            w_ifidNext.inst  = NOP_INST;
            w_holdClear      = 1'b1;
          end else begin
            w_holdTake    = 1'b1;
            w_deliver     = w_holdValid;
            w_deliverData = w_holdData;
          end
`endif
        end
      end

      DROP: begin
        if (imem_rvalid) begin
          w_nextState = FETCH;
        end
`ifndef IF_STAGE_DELAY_SLOT_EN
        if (!id_stall && id_redirect) begin
          w_fetchNext      = w_target;
          w_ifidNext.valid = 1'b0;
          w_ifidNext.inst  = NOP_INST;
        end
`endif
      end

      default: begin
        w_nextState = FETCH;
      end
    endcase

    if (w_deliver) begin
      w_ifidNext.valid = 1'b1;
      w_ifidNext.pc    = r_fetchPc;
      w_ifidNext.pc4   = pc_plus4(r_fetchPc);
      w_ifidNext.inst  = w_deliverData;
      w_fetchNext      = w_advPc;
    end
  end

  // The request address is frozen while a discarded request is still in flight.
  assign w_reqAddrNext = (w_nextState == DROP) ? r_reqAddr : w_fetchNext;

`ifdef IF_STAGE_DELAY_SLOT_EN
  // Pending target survives until the delay-slot instruction is delivered.
  always_comb begin
    w_pendValidNext  = w_havePend;
    w_pendTargetNext = w_pendTgt;
    if (w_deliver) begin
      w_pendValidNext = 1'b0;
    end
  end

  // Pending-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pendValid  <= 1'b0;
      r_pendTarget <= START_PC;
    end else begin
      r_pendValid  <= w_pendValidNext;
      r_pendTarget <= w_pendTargetNext;
    end
  end
`endif

  // State, fetch PC, request address and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_fetchPc  <= START_PC;
      r_reqAddr  <= START_PC;
      r_ifid     <= '{valid: 1'b0, pc: START_PC, pc4: pc_plus4(START_PC), inst: NOP_INST};
    end else begin
      r_state    <= w_nextState;
      r_fetchPc  <= w_fetchNext;
      r_reqAddr  <= w_reqAddrNext;
      r_ifid     <= w_ifidNext;
    end
  end

  assign imem_req  = ~rst & (r_state != HOLD);
  assign imem_addr = r_reqAddr;
  assign if_valid  = r_ifid.valid;
  assign if_pc     = r_ifid.pc;
  assign if_pc4    = r_ifid.pc4;
  assign if_inst   = r_ifid.inst;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by a randomized run
// against a transaction-level fetch model.
module tb_if_stage;

  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam logic [31:0] RPC         = 32'h0000_0000;
  localparam logic [31:0] RPC2        = 32'hFFFF_FFFC;
  localparam int          RAND_CYCLES = 800;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        id_stall;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;

  logic        req2;
  logic [31:0] addr2;
  logic [31:0] rdata2;
  logic        rvalid2;
  logic        stall2 = 1'b0;
  logic        redir2 = 1'b0;
  logic [31:0] target2 = 32'h0;
  logic        valid2;
  logic [31:0] pc2;
  logic [31:0] pc4x2;
  logic [31:0] inst2;

  int checks   = 0;
  int failures = 0;

  // model / memory state
  logic [31:0] expFetch;
  logic        mValid;
  logic [31:0] mPc;
  logic [31:0] mInst;
  logic        pend;
  logic [31:0] pTgt;
  int          heldCount;
  int          deliveries;
  logic        outst;
  logic        stale;
  int          lat;
  logic [31:0] capAddr;
  logic        s;
  logic        r;
  logic [31:0] t;
  logic        given;
  logic        gStale;

  always #5 clk = ~clk;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign rvalid2 = req2;
  assign rdata2  = memFn(addr2);

  if_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .id_stall(id_stall),
    .id_redirect(id_redirect), .id_target(id_target), .if_valid(if_valid),
    .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst)
  );

  if_stage #(.RESET_PC(RPC2), .NOP_INST(NOP)) dutWrap (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(rdata2), .imem_rvalid(rvalid2), .id_stall(stall2),
    .id_redirect(redir2), .id_target(target2), .if_valid(valid2),
    .if_pc(pc2), .if_pc4(pc4x2), .if_inst(inst2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given memory response; returns #1 after the edge.
  task automatic applyStimulus(input logic rv, input logic [31:0] data);
    imem_rvalid = rv;
    imem_rdata  = data;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
  endtask

  task automatic modelDeliver();
    mValid = 1'b1;
    mPc    = expFetch;
    mInst  = memFn(expFetch);
    expFetch = pend ? pTgt : expFetch + 32'd4;
    pend   = 1'b0;
    deliveries++;
  endtask

  initial begin
    rst = 1'b1; id_stall = 1'b0; id_redirect = 1'b0; id_target = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(posedge clk);
    #1;

    // reset state, stray response during reset ignored
    #1 checkOutput("reset_req", imem_req, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF);
    checkOutput("reset_valid", if_valid, 1'b0);
    checkOutput("reset_pc", if_pc, RPC);
    checkOutput("reset_pc4", if_pc4, RPC + 32'd4);
    checkOutput("reset_inst", if_inst, NOP);
    checkOutput("wrap_reset_pc", pc2, RPC2);
    checkOutput("wrap_reset_pc4", pc4x2, 32'h0);

    // same-cycle memory: one instruction per cycle
    rst = 1'b0;
    #1 checkOutput("seq_req", imem_req, 1'b1);
    checkOutput("seq_addr0", imem_addr, 32'h0);
    applyStimulus(1'b1, memFn(32'h0));
    checkOutput("seq_pc0", if_pc, 32'h0);
    checkOutput("seq_valid0", if_valid, 1'b1);
    checkOutput("seq_inst0", if_inst, memFn(32'h0));
    checkOutput("wrap_pc_a", pc2, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4_a", pc4x2, 32'h0);
    #1 checkOutput("seq_addr4", imem_addr, 32'h4);
    applyStimulus(1'b1, memFn(32'h4));
    checkOutput("seq_pc4", if_pc, 32'h4);
    checkOutput("wrap_pc_b", pc2, 32'h0);
    checkOutput("wrap_pc4_b", pc4x2, 32'h4);
    #1 checkOutput("seq_addr8", imem_addr, 32'h8);
    applyStimulus(1'b1, memFn(32'h8));
    checkOutput("seq_pc8", if_pc, 32'h8);
    checkOutput("seq_pc4_8", if_pc4, 32'hC);

    // stall while a response arrives: hold, then release
    id_stall = 1'b1;
    #1 checkOutput("stall_addr", imem_addr, 32'hC);
    applyStimulus(1'b1, memFn(32'hC));
    checkOutput("stall_frozen0", if_pc, 32'h8);
    checkOutput("stall_req0", imem_req, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0);
      checkOutput("stall_frozen", if_pc, 32'h8);
      checkOutput("stall_inst", if_inst, memFn(32'h8));
      checkOutput("stall_req", imem_req, 1'b0);
    end
    id_stall = 1'b0;
    applyStimulus(1'b0, 32'h0);
    checkOutput("unstall_pc", if_pc, 32'hC);
    checkOutput("unstall_inst", if_inst, memFn(32'hC));
    checkOutput("unstall_valid", if_valid, 1'b1);
    #1 checkOutput("unstall_req", imem_req, 1'b1);
    checkOutput("unstall_addr", imem_addr, 32'h10);
    applyStimulus(1'b1, memFn(32'h10));
    checkOutput("unstall_next_pc", if_pc, 32'h10);

    // redirect to 0x40 while address 8 has a 3-cycle latency outstanding
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b1, memFn(32'h0));
    applyStimulus(1'b1, memFn(32'h4));
    #1 checkOutput("redir_addr8", imem_addr, 32'h8);
    applyStimulus(1'b0, 32'h0);
    id_redirect = 1'b1;
    id_target   = 32'h0000_0043;
    applyStimulus(1'b0, 32'h0);
    id_redirect = 1'b0;
    checkOutput("redir_req", imem_req, 1'b1);
    checkOutput("redir_addr_held", imem_addr, 32'h8);
`ifdef IF_STAGE_DELAY_SLOT_EN
    checkOutput("ds_no_bubble", if_valid, 1'b1);
    checkOutput("ds_pc_prev", if_pc, 32'h4);
    applyStimulus(1'b1, memFn(32'h8));
    checkOutput("ds_slot_pc", if_pc, 32'h8);
    checkOutput("ds_slot_valid", if_valid, 1'b1);
`else
    checkOutput("redir_bubble", if_valid, 1'b0);
    checkOutput("redir_nop", if_inst, NOP);
    applyStimulus(1'b1, memFn(32'h8));
    checkOutput("redir_dropped", if_valid, 1'b0);
`endif
    #1 checkOutput("redir_new_addr", imem_addr, 32'h40);
    applyStimulus(1'b1, memFn(32'h40));
    checkOutput("redir_pc", if_pc, 32'h40);
    checkOutput("redir_pc4", if_pc4, 32'h44);
    checkOutput("redir_inst", if_inst, memFn(32'h40));
    checkOutput("redir_valid", if_valid, 1'b1);

    // reset while a discarded request is in flight, late response arrives
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b1, memFn(32'h0));
    id_redirect = 1'b1;
    id_target   = 32'h80;
    applyStimulus(1'b0, 32'h0);
    id_redirect = 1'b0;
    rst = 1'b1;
    #1 checkOutput("rstdrop_req", imem_req, 1'b0);
    applyStimulus(1'b1, 32'hBAD0_BAD0);
    checkOutput("rstdrop_valid", if_valid, 1'b0);
    checkOutput("rstdrop_pc", if_pc, RPC);
    checkOutput("rstdrop_pc4", if_pc4, RPC + 32'd4);
    checkOutput("rstdrop_inst", if_inst, NOP);
    rst = 1'b0;
    #1 checkOutput("rstdrop_restart_req", imem_req, 1'b1);
    checkOutput("rstdrop_restart_addr", imem_addr, RPC);
    applyStimulus(1'b1, memFn(32'h0));
    checkOutput("rstdrop_first_pc", if_pc, 32'h0);
    checkOutput("rstdrop_first_inst", if_inst, memFn(32'h0));

    // randomized run against the fetch model
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0);
    rst = 1'b0;
    expFetch = RPC; mValid = 1'b0; mPc = RPC; mInst = NOP;
    pend = 1'b0; pTgt = 32'h0; heldCount = 0; deliveries = 0;
    outst = 1'b0; stale = 1'b0; lat = 0; capAddr = 32'h0;
    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 12);
      t = 32'($urandom_range(0, 1023));
      id_stall = s; id_redirect = r; id_target = t;
      #1;
      given = 1'b0;
      gStale = 1'b0;
      if (imem_req) begin
        if (!outst) begin
          outst = 1'b1;
          stale = 1'b0;
          capAddr = imem_addr;
          lat = $urandom_range(0, 3);
          checkOutput("rnd_req_addr", imem_addr, expFetch);
        end else begin
          checkOutput("rnd_addr_stable", imem_addr, capAddr);
        end
        if (lat == 0) begin
          given = 1'b1;
          gStale = stale;
          outst = 1'b0;
        end else begin
          lat--;
        end
      end
      applyStimulus(given, given ? memFn(capAddr) : $urandom);

`ifdef IF_STAGE_DELAY_SLOT_EN
      if (!s && r) begin
        pend = 1'b1;
        pTgt = t & 32'hFFFF_FFFC;
      end
      if (s) begin
        if (given) heldCount++;
      end else if (heldCount > 0) begin
        heldCount--;
        modelDeliver();
      end else if (given) begin
        modelDeliver();
      end
`else
      if (s) begin
        if (given && !gStale) heldCount++;
      end else if (r) begin
        heldCount = 0;
        mValid = 1'b0;
        mInst = NOP;
        expFetch = t & 32'hFFFF_FFFC;
        if (outst) stale = 1'b1;
      end else if (heldCount > 0) begin
        heldCount--;
        modelDeliver();
      end else if (given && !gStale) begin
        modelDeliver();
      end
`endif

      checkOutput("rnd_valid", if_valid, mValid);
      checkOutput("rnd_inst", if_inst, mInst);
      if (mValid) begin
        checkOutput("rnd_pc", if_pc, mPc);
        checkOutput("rnd_pc4", if_pc4, mPc + 32'd4);
      end
    end
    checkOutput("rnd_progress", 32'(deliveries > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
